load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/rv32i_pkg.sv | 26 ++
 rtl/lsu_load_align.sv | 26 ++
 rtl/load_store_unit.sv | 131 +++++++++++++
 tb/tb_load_store_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared funct3 encodings, access-size helpers and LSU FSM state encoding
package rv32i_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    // Access size lives in funct3[1:0]; anything that is not byte or half is a word.
    function automatic logic [1:0] f3_size(input logic [2:0] f3);
        return f3[1:0];
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: picks the addressed lane out of a memory word and sign/zero-extends it
module lsu_load_align
    import rv32i_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       funct3,
    input  logic [1:0]       off,
    input  logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] data
);

    logic [15:0] half;

    assign half = 16'(rdata >> {off, 3'b000});

    // Unknown funct3 values fall through to the full-word pass-through.
    always_comb begin
        data = funct3 == F3_LB  ? {{(WIDTH-8){half[7]}}, half[7:0]} :
               funct3 == F3_LBU ? {{(WIDTH-8){1'b0}}, half[7:0]} :
               funct3 == F3_LH  ? {{(WIDTH-16){half[15]}}, half} :
               funct3 == F3_LHU ? {{(WIDTH-16){1'b0}}, half} :
               rdata;
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding RV32I load/store unit between execute and data memory.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses skip memory and return rsp_err.
module load_store_unit
    import rv32i_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic             mem_req,
    input  logic             mem_gnt,
    output logic             mem_we,
    output logic [3:0]       mem_be,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_rvalid,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]       state;
    logic             we_q;
    logic [2:0]       f3_q;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic [WIDTH-1:0] rdata_q;
    logic             err_q;
    logic [CW-1:0]    cnt;
    logic [1:0]       off;
    logic [1:0]       sz;
    logic [3:0]       be;
    logic [WIDTH-1:0] wlanes;
    logic [WIDTH-1:0] load_data;
    logic             misalign;

    assign off = addr_q[1:0];
    assign sz  = f3_size(f3_q);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = (f3_size(req_funct3) == SZ_H) ? req_addr[0] :
                      (f3_size(req_funct3) != SZ_B) && (req_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // Byte enables and replicated store lanes from the registered request.
    always_comb begin
        be     = sz == SZ_B ? 4'b0001 << off : sz == SZ_H ? 4'b0011 << off : 4'b1111;
        wlanes = sz == SZ_B ? {(WIDTH/8){wdata_q[7:0]}} :
                 sz == SZ_H ? {(WIDTH/16){wdata_q[15:0]}} : wdata_q;
    end

    lsu_load_align #(.WIDTH(WIDTH)) u_align (
        .funct3 (f3_q),
        .off    (off),
        .rdata  (mem_rdata),
        .data   (load_data)
    );

    // Memory-side outputs are only live while requesting; otherwise they rest at zero.
    always_comb begin
        req_ready = state == S_IDLE;
        mem_req   = state == S_REQ;
        mem_we    = mem_req & we_q;
        mem_be    = mem_req ? be : 4'b0000;
        mem_addr  = mem_req ? {addr_q[WIDTH-1:2], 2'b00} : '0;
        mem_wdata = mem_req ? wlanes : '0;
        rsp_valid = state == S_RESP;
        rsp_rdata = rsp_valid ? rdata_q : '0;
        rsp_err   = rsp_valid & err_q;
    end

    // Transaction FSM with a shared wait counter for the grant and read-data phases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
                    we_q    <= req_we;
                    f3_q    <= req_funct3;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    rdata_q <= '0;
                    err_q   <= misalign;
                    cnt     <= '0;
                    state   <= misalign ? S_RESP : S_REQ;
                end
                S_REQ: if (mem_gnt) begin
                    cnt   <= '0;
                    state <= we_q ? S_RESP : S_WAIT;
                end else if (cnt == CNT_LAST) begin
                    err_q <= 1'b1;
                    state <= S_RESP;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                S_WAIT: if (mem_rvalid) begin
                    rdata_q <= load_data;
                    state   <= S_RESP;
                end else if (cnt == CNT_LAST) begin
                    err_q <= 1'b1;
                    state <= S_RESP;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven directed checks of load_store_unit with TIMEOUT=4
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_req;
    logic        mem_gnt = 1'b0;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    load_store_unit #(.WIDTH(32), .TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdin;
        int          gd;
        int          rd;
        logic [3:0]  be;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        int          nreq;
        int          lat;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    typedef struct {
        logic        rdy;
        logic [3:0]  be;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic        mwe;
        int          nreq;
        int          lat;
        logic [31:0] rdata;
        logic        err;
        logic        unstable;
        logic        after_valid;
        logic        after_ready;
    } obs_t;

    vec_t vt[13];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Drives one request and plays the memory: gnt after gd stalled REQ cycles, rvalid after rd stalled
    // WAIT cycles. rvalid is held high with junk data during REQ to prove it is ignored there.
    task automatic txn(input vec_t v, output obs_t o);
        bit done = 0;
        bit granted = 0;
        int nreq = 0;
        int nwait = 0;
        o = '{default: 0};
        @(negedge clk);
        o.rdy = req_ready;
        req_valid = 1'b1;
        req_we = v.we;
        req_funct3 = v.f3;
        req_addr = v.addr;
        req_wdata = v.wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 1; i <= 40 && !done; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                o.lat = i;
                o.rdata = rsp_rdata;
                o.err = rsp_err;
                done = 1;
                mem_gnt = 1'b0;
                mem_rvalid = 1'b0;
            end else if (mem_req) begin
                nreq++;
                if (nreq == 1) begin
                    o.be = mem_be;
                    o.maddr = mem_addr;
                    o.mwdata = mem_wdata;
                    o.mwe = mem_we;
                end else if ({mem_we, mem_be, mem_addr, mem_wdata} !== {o.mwe, o.be, o.maddr, o.mwdata}) begin
                    o.unstable = 1'b1;
                end
                mem_gnt = nreq > v.gd;
                granted = mem_gnt;
                mem_rvalid = 1'b1;
                mem_rdata = 32'h5A5A5A5A;
            end else if (granted) begin
                nwait++;
                mem_gnt = 1'b0;
                mem_rvalid = nwait > v.rd;
                mem_rdata = mem_rvalid ? v.rdin : 32'hA5A5A5A5;
            end
        end
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        o.nreq = nreq;
        @(negedge clk);
        o.after_valid = rsp_valid;
        o.after_ready = req_ready;
    endtask

    initial begin
        obs_t o;
        bit seen;
        //         we f3      addr       wdata          rdin          gd rd be       maddr      mwdata         nreq lat rdata          err
        vt[0]  = '{1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        0, 0, 4'b1111, 32'h100, 32'hDEADBEEF, 1, 2, 32'h0,        0};
        vt[1]  = '{0, 3'b000, 32'h103, 32'h0,        32'h80FFFFFF, 0, 0, 4'b1000, 32'h100, 32'h0,        1, 3, 32'hFFFFFF80, 0};
        vt[2]  = '{0, 3'b100, 32'h103, 32'h0,        32'h80FFFFFF, 0, 0, 4'b1000, 32'h100, 32'h0,        1, 3, 32'h00000080, 0};
        vt[3]  = '{1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0,        0, 0, 4'b1100, 32'h100, 32'hABCDABCD, 1, 2, 32'h0,        0};
        vt[4]  = '{1, 3'b000, 32'h201, 32'h000000A5, 32'h0,        0, 0, 4'b0010, 32'h200, 32'hA5A5A5A5, 1, 2, 32'h0,        0};
        vt[5]  = '{0, 3'b001, 32'h202, 32'h0,        32'h80017F00, 0, 0, 4'b1100, 32'h200, 32'h0,        1, 3, 32'hFFFF8001, 0};
        vt[6]  = '{0, 3'b101, 32'h200, 32'h0,        32'h8001F234, 0, 0, 4'b0011, 32'h200, 32'h0,        1, 3, 32'h0000F234, 0};
        vt[7]  = '{0, 3'b010, 32'h300, 32'h0,        32'hCAFEF00D, 3, 2, 4'b1111, 32'h300, 32'h0,        4, 8, 32'hCAFEF00D, 0};
        vt[8]  = '{0, 3'b011, 32'h040, 32'h0,        32'h12345678, 0, 0, 4'b1111, 32'h040, 32'h0,        1, 3, 32'h12345678, 0};
        vt[9]  = '{1, 3'b010, 32'h080, 32'h00000011, 32'h0,       99, 0, 4'b1111, 32'h080, 32'h00000011, 4, 5, 32'h0,        1};
        vt[10] = '{0, 3'b010, 32'h010, 32'h0,        32'h1,        0,99, 4'b1111, 32'h010, 32'h0,        1, 6, 32'h0,        1};
`ifdef LSU_MISALIGN_TRAP_EN
        vt[11] = '{0, 3'b010, 32'h101, 32'h0,        32'hA1B2C3D4, 0, 0, 4'b0000, 32'h0,   32'h0,        0, 1, 32'h0,        1};
        vt[12] = '{1, 3'b001, 32'h103, 32'h0000BEEF, 32'h0,        0, 0, 4'b0000, 32'h0,   32'h0,        0, 1, 32'h0,        1};
`else
        vt[11] = '{0, 3'b010, 32'h101, 32'h0,        32'hA1B2C3D4, 0, 0, 4'b1111, 32'h100, 32'h0,        1, 3, 32'hA1B2C3D4, 0};
        vt[12] = '{1, 3'b001, 32'h103, 32'h0000BEEF, 32'h0,        0, 0, 4'b1000, 32'h100, 32'hBEEFBEEF, 1, 2, 32'h0,        0};
`endif

        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);

        mem_gnt = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            seen |= mem_req | rsp_valid;
        end
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        chk("idle_ignores_gnt_rvalid", seen, 0);

        for (int i = 0; i < 13; i++) begin
            txn(vt[i], o);
            chk($sformatf("v%0d_ready", i), o.rdy, 1);
            chk($sformatf("v%0d_be", i), o.be, vt[i].be);
            chk($sformatf("v%0d_addr", i), o.maddr, vt[i].maddr);
            chk($sformatf("v%0d_wdata", i), o.mwdata, vt[i].mwdata);
            chk($sformatf("v%0d_we", i), o.mwe, vt[i].nreq > 0 ? vt[i].we : 1'b0);
            chk($sformatf("v%0d_req_cycles", i), o.nreq, vt[i].nreq);
            chk($sformatf("v%0d_latency", i), o.lat, vt[i].lat);
            chk($sformatf("v%0d_rdata", i), o.rdata, vt[i].rdata);
            chk($sformatf("v%0d_err", i), o.err, vt[i].err);
            chk($sformatf("v%0d_stable", i), o.unstable, 0);
            chk($sformatf("v%0d_resp_one_cycle", i), o.after_valid, 0);
            chk($sformatf("v%0d_ready_after", i), o.after_ready, 1);
        end

        @(negedge clk);
        req_valid = 1'b1;
        req_we = 1'b0;
        req_funct3 = 3'b010;
        req_addr = 32'h500;
        req_wdata = 32'h0;
        mem_gnt = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstw_in_req", mem_req, 1);
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("rstw_in_wait", mem_req | req_ready | rsp_valid, 0);
        #1 rst = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata = 32'h13572468;
        #1;
        chk("rstw_rsp_valid", rsp_valid, 0);
        chk("rstw_rsp_rdata", rsp_rdata, 0);
        chk("rstw_rsp_err", rsp_err, 0);
        chk("rstw_mem_outs", {mem_req, mem_we, mem_be, mem_addr, mem_wdata} != '0, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            seen |= rsp_valid;
        end
        mem_rvalid = 1'b0;
        chk("rstw_no_response", seen, 0);
        chk("rstw_ready", req_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
